// File: rtl/shift_norm_pkg.sv
// Shared constants and state encoding for the leading-one normalization controller.
package shift_norm_pkg;

  localparam int unsigned NORM_WIDTH = 16;
  localparam int unsigned NORM_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_norm_counter.sv
// Shift counter: sync clear and enable, with a terminal flag at WIDTH-1.
module shift_norm_counter
  import shift_norm_pkg::*;
#(
  parameter int unsigned WIDTH = NORM_WIDTH,
  parameter int unsigned CNT_W = NORM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_term
);

  logic [CNT_W-1:0] r_cnt;

  // Count shifts; cleared on reset or at operand load.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_norm_ctrl.sv
// Leading-one normalization controller for a load/shift-left register.
// Optional feature: define SHIFT_NORM_ZERO_DETECT_EN to end early on a zero operand
// using reg_zero; otherwise a zero operand is found by hitting the shift limit.
module shift_norm_ctrl
  import shift_norm_pkg::*;
#(
  parameter  int unsigned WIDTH = NORM_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             reg_msb,
  input  logic             reg_zero,
  output logic             ld_reg,
  output logic             shl_reg,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero_flag
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_cnt_clr;
  logic   w_cnt_en;
  logic   w_cnt_term;
  logic   w_zero_set;
  logic   w_zero_hit;
  logic   r_zero_flag;

`ifdef SHIFT_NORM_ZERO_DETECT_EN
  assign w_zero_hit = reg_zero;
`else
  logic w_unused_reg_zero;
  assign w_unused_reg_zero = reg_zero;
  assign w_zero_hit        = 1'b0;
`endif

  shift_norm_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_cnt  (shift_cnt),
    .o_term (w_cnt_term)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and register control; ld/shl decode lets the register act on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    ld_reg      = 1'b0;
    shl_reg     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_zero_set  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_reg      = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_zero_hit) begin
          w_zero_set  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (reg_msb) begin
          w_state_nxt = S_DONE;
        end else if (w_cnt_term) begin
          w_zero_set  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          shl_reg  = 1'b1;
          w_cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Zero flag: cleared at load, set when the operand turns out to hold no 1.
  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr) begin
      r_zero_flag <= 1'b0;
    end else if (w_zero_set) begin
      r_zero_flag <= 1'b1;
    end
  end

  assign zero_flag = r_zero_flag;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_norm_ctrl.sv
// Bench for shift_norm_ctrl: models the 16-bit load/shift register and the
// controller's transaction-level timing; honours SHIFT_NORM_ZERO_DETECT_EN.
module tb_shift_norm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] operand = 16'h0;
  logic [15:0] q = 16'h0;
  logic        reg_msb, reg_zero;
  logic        ld_reg, shl_reg, busy, done, zero_flag;
  logic [3:0]  shift_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit          m_run = 1'b0;
  int          m_t = 0;
  int          m_k = 0;
  logic [15:0] m_op = 16'h0;
  int          m_cnt = 0;
  bit          m_zf = 1'b0;

  always #5 clk = ~clk;

  shift_norm_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reg_msb   (reg_msb),
    .reg_zero  (reg_zero),
    .ld_reg    (ld_reg),
    .shl_reg   (shl_reg),
    .busy      (busy),
    .done      (done),
    .shift_cnt (shift_cnt),
    .zero_flag (zero_flag)
  );

  // The normalized register the controller drives
  always @(posedge clk) begin
    if (ld_reg)       q <= operand;
    else if (shl_reg) q <= q << 1;
  end
  assign reg_msb  = q[15];
  assign reg_zero = (q == 16'h0);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Shifts (and result count) needed for an operand
  function automatic int exp_k(input logic [15:0] op);
    int k;
    if (op == 16'h0) begin
`ifdef SHIFT_NORM_ZERO_DETECT_EN
      return 0;
`else
      return 15;
`endif
    end
    k = 0;
    while (op[15 - k] == 1'b0) k++;
    return k;
  endfunction

  // Transaction model: t counts cycles after the accepting edge; done at t==k+2
  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_cnt = 0; m_zf = 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1'b1; m_t = 0;
      end
    end else begin
      if (m_t == 0) begin
        m_op = operand;
        m_k  = exp_k(operand);
      end
      m_t++;
      if (m_t == m_k + 2) begin
        m_cnt = m_k;
        m_zf  = (m_op == 16'h0);
      end
      if (m_t > m_k + 2) m_run = 1'b0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (done) n_done++;
      chk("busy",    int'(busy),    int'(m_run));
      chk("done",    int'(done),    int'(m_run && m_t == m_k + 2));
      chk("ld_reg",  int'(ld_reg),  int'(m_run && m_t == 0));
      chk("shl_reg", int'(shl_reg), int'(m_run && m_t >= 1 && m_t <= m_k));
      chk("ld_shl_excl", int'(ld_reg && shl_reg), 0);
      if (!m_run || done) begin
        chk("shift_cnt", int'(shift_cnt), m_cnt);
        chk("zero_flag", int'(zero_flag), int'(m_zf));
      end
    end
  end

  // Start one run and check the literal result and latency
  task automatic run_op(input logic [15:0] op, input int e_cnt, input int e_zf, input int e_lat);
    int n;
    @(negedge clk); operand = op; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk); n++;
    end
    chk("latency",      n, e_lat);
    chk("lit_cnt",      int'(shift_cnt), e_cnt);
    chk("lit_zero_flag", int'(zero_flag), e_zf);
    @(negedge clk);
  endtask

  function automatic logic [15:0] gen_op();
    if ($urandom_range(0, 4) == 0) return 16'h0;
    return 16'($urandom) >> $urandom_range(0, 15);
  endfunction

  initial begin
    int n;
    int d0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt",  int'(shift_cnt), 0);
    chk("rst_zf",   int'(zero_flag), 0);
    chk("rst_ld",   int'(ld_reg), 0);
    chk("rst_shl",  int'(shl_reg), 0);
    chk_en = 1'b1;

    // 1. MSB already set
    run_op(16'h8000, 0, 0, 3);
    // 2. Single low bit: 15 shifts
    run_op(16'h0001, 15, 0, 18);
    chk("reg_value", int'(q), 16'h8000);
    // 3. Zero operand
`ifdef SHIFT_NORM_ZERO_DETECT_EN
    run_op(16'h0000, 0, 1, 3);
`else
    run_op(16'h0000, 15, 1, 18);
`endif

    // 4. Reset during the second SHIFT cycle
    d0 = n_done;
    @(negedge clk); operand = 16'h00F0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_cnt",  int'(shift_cnt), 0);
    chk("abort_done", int'(done), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    run_op(16'h0F00, 4, 0, 7);

    // 5. start pulses while busy are ignored
    d0 = n_done;
    @(negedge clk); operand = 16'h0004; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 40 && busy; c++) begin
      start = c[0];
      @(negedge clk); start = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("one_done_per_start", n_done - d0, 1);

    // 6. start held high across two runs
    @(negedge clk); operand = 16'h4000; start = 1'b1;
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("held_lat1", n, 4);
    chk("held_cnt1", int'(shift_cnt), 1);
    operand = 16'h0800;
    @(negedge clk);
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("held_cnt2", int'(shift_cnt), 4);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Random operands, ignored start pulses and occasional aborts
    for (int it = 0; it < 60; it++) begin
      bit abort;
      int abort_at;
      int c;
      abort    = ($urandom_range(0, 7) == 0);
      abort_at = $urandom_range(1, 10);
      @(negedge clk); operand = gen_op(); start = 1'b1;
      @(negedge clk); start = 1'b0;
      c = 0;
      while (busy && c < 40) begin
        start = ($urandom_range(0, 3) == 0);
        if (abort && c == abort_at) rst = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        c++;
      end
      if (c >= 40) chk("run_timeout", int'(busy), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
